// File: rtl/knn_majority_vote_pkg.sv
// Shared definitions for the KNN vote block: FSM states, clog2 and vote-total sizing.
// Macro KNN_VOTE_WEIGHTED_EN selects the distance-weighted vote and widens the totals.
package knn_majority_vote_pkg;

  localparam int KNN_TYPE_W = 32;

  typedef enum logic [1:0] {
    KNN_S_IDLE   = 2'd0,
    KNN_S_COUNT  = 2'd1,
    KNN_S_ARGMAX = 2'd2,
    KNN_S_DONE   = 2'd3
  } knn_state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Width that holds the largest possible per-class total without overflow.
  function automatic int vote_cw(input int k);
`ifdef KNN_VOTE_WEIGHTED_EN
    return clog2(k * (k + 1) / 2 + 1);
`else
    return clog2(k + 1);
`endif
  endfunction

endpackage

// File: rtl/knn_majority_vote_if.sv
// Start/done handshake and result bus between a vote requester and knn_majority_vote.
interface knn_majority_vote_if
  import knn_majority_vote_pkg::*;
#(
  parameter int N = 64,
  parameter int B = KNN_TYPE_W,
  parameter int K = 5,
  parameter int C = 8
) ();

  localparam int CW = vote_cw(K);

  logic           start;
  logic [N*B-1:0] type_sorted;
  logic           busy;
  logic           done;
  logic [B-1:0]   class_out;
  logic [CW-1:0]  vote_cnt;
  logic           bad_type;

  modport master (
    output start, type_sorted,
    input  busy, done, class_out, vote_cnt, bad_type
  );

  modport slave (
    input  start, type_sorted,
    output busy, done, class_out, vote_cnt, bad_type
  );

endinterface

// File: rtl/knn_majority_vote_argmax_scan.sv
// Sequential argmax: one candidate per step, replaced only on strictly greater value.
// Latency: result valid the cycle after the last step; no backpressure, caller paces step.
module knn_argmax_scan #(
  parameter int VW = 4,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          step,
  input  logic [VW-1:0] value,
  input  logic [IW-1:0] index,
  output logic [VW-1:0] best_val,
  output logic [IW-1:0] best_idx
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_val <= '0;
      best_idx <= '0;
    end else if (clear) begin
      best_val <= '0;
      best_idx <= '0;
    end else if (step && (value > best_val)) begin
      best_val <= value;
      best_idx <= index;
    end
  end

endmodule

// File: rtl/knn_majority_vote.sv
// Majority vote over the K nearest sorted types (weighted when KNN_VOTE_WEIGHTED_EN is defined).
// Latency K+C+2 cycles start-to-done; start ignored while busy or done, never queued.
module knn_majority_vote
  import knn_majority_vote_pkg::*;
#(
  parameter int N = 64,
  parameter int B = KNN_TYPE_W,
  parameter int K = 5,
  parameter int C = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  knn_majority_vote_if.slave vif
);

  localparam int CW  = vote_cw(K);
  localparam int CIW = (C > 1) ? clog2(C) : 1;
  localparam int IW  = clog2(((K > C) ? K : C) + 1);
  localparam logic [B-1:0] C_B = B'(C);

  knn_state_t     state, state_n;
  logic [IW-1:0]  idx;
  logic [B-1:0]   shadow [K];
  logic [CW-1:0]  cnt [C];
  logic [CW-1:0]  weight;
  logic [B-1:0]   class_q;
  logic [CW-1:0]  vote_q;
  logic           bad_q;
  logic           accept, last_count, scan_step, scan_done;
  logic [CW-1:0]  best_val;
  logic [CIW-1:0] best_idx;

  // Entries beyond the K voters never influence the result.
  generate
    if (K < N) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^vif.type_sorted[N*B-1:K*B];
    end
  endgenerate

`ifdef KNN_VOTE_WEIGHTED_EN
  assign weight = CW'(K) - CW'(idx);
`else
  assign weight = CW'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= KNN_S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    last_count = 1'b0;
    scan_step  = 1'b0;
    scan_done  = 1'b0;
    case (state)
      KNN_S_IDLE: if (vif.start) begin
        accept  = 1'b1;
        state_n = KNN_S_COUNT;
      end
      KNN_S_COUNT: if (idx == IW'(K - 1)) begin
        last_count = 1'b1;
        state_n    = KNN_S_ARGMAX;
      end
      // Index C is a drain cycle: the last step's result is registered by then.
      KNN_S_ARGMAX: if (idx == IW'(C)) begin
        scan_done = 1'b1;
        state_n   = KNN_S_DONE;
      end else begin
        scan_step = 1'b1;
      end
      KNN_S_DONE: state_n = KNN_S_IDLE;
      default:    state_n = KNN_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      bad_q   <= 1'b0;
      class_q <= '0;
      vote_q  <= '0;
      for (int i = 0; i < K; i++) shadow[i] <= '0;
      for (int c = 0; c < C; c++) cnt[c] <= '0;
    end else begin
      case (state)
        KNN_S_IDLE: if (accept) begin
          idx   <= '0;
          bad_q <= 1'b0;
          for (int i = 0; i < K; i++) shadow[i] <= vif.type_sorted[i*B +: B];
          for (int c = 0; c < C; c++) cnt[c] <= '0;
        end
        KNN_S_COUNT: begin
          if (shadow[0] < C_B) cnt[shadow[0][CIW-1:0]] <= cnt[shadow[0][CIW-1:0]] + weight;
          else                 bad_q <= 1'b1;
          for (int i = 0; i < K - 1; i++) shadow[i] <= shadow[i+1];
          idx <= last_count ? '0 : idx + 1'b1;
        end
        KNN_S_ARGMAX: begin
          idx <= idx + 1'b1;
          if (scan_done) begin
            class_q <= B'(best_idx);
            vote_q  <= best_val;
          end
        end
        default: ;
      endcase
    end
  end

  knn_argmax_scan #(.VW(CW), .IW(CIW)) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .step     (scan_step),
    .value    (cnt[idx[CIW-1:0]]),
    .index    (idx[CIW-1:0]),
    .best_val (best_val),
    .best_idx (best_idx)
  );

  assign vif.busy      = (state == KNN_S_COUNT) || (state == KNN_S_ARGMAX);
  assign vif.done      = (state == KNN_S_DONE);
  assign vif.class_out = class_q;
  assign vif.vote_cnt  = vote_q;
  assign vif.bad_type  = bad_q;

endmodule

// File: tb/tb_knn_majority_vote.sv
// Directed-vector bench for knn_majority_vote (K=5, C=8), both KNN_VOTE_WEIGHTED_EN settings.
module tb_knn_majority_vote;
  import knn_majority_vote_pkg::*;

  localparam int N = 64;
  localparam int B = 32;
  localparam int K = 5;
  localparam int C = 8;
  localparam int NV = 9;

  typedef struct {
    int t0, t1, t2, t3, t4;
    int cls, cnt, bad;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vt [NV];

  always #5 clk = ~clk;

  knn_majority_vote_if #(.N(N), .B(B), .K(K), .C(C)) vif ();

  knn_majority_vote #(.N(N), .B(B), .K(K), .C(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  function automatic vec_t mk(input int a0, a1, a2, a3, a4, cls, cnt, bad);
    vec_t v;
    v.t0 = a0; v.t1 = a1; v.t2 = a2; v.t3 = a3; v.t4 = a4;
    v.cls = cls; v.cnt = cnt; v.bad = bad;
    return v;
  endfunction

  // Independent reference: tally per class, then pick the first class with the highest tally.
  function automatic vec_t model(input vec_t v);
    int tt [5];
    int tally [C];
    vec_t r;
    tt = '{v.t0, v.t1, v.t2, v.t3, v.t4};
    r = v;
    r.bad = 0;
    for (int c = 0; c < C; c++) tally[c] = 0;
    for (int i = 0; i < 5; i++) begin
      if (tt[i] >= C) r.bad = 1;
`ifdef KNN_VOTE_WEIGHTED_EN
      else tally[tt[i]] += (5 - i);
`else
      else tally[tt[i]] += 1;
`endif
    end
    r.cls = 0;
    r.cnt = 0;
    for (int c = C - 1; c >= 0; c--)
      if (tally[c] >= r.cnt) begin r.cnt = tally[c]; r.cls = c; end
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_types(input vec_t v);
    for (int i = 0; i < N; i++) vif.type_sorted[i*B +: B] = 32'd7;
    vif.type_sorted[0*B +: B] = v.t0;
    vif.type_sorted[1*B +: B] = v.t1;
    vif.type_sorted[2*B +: B] = v.t2;
    vif.type_sorted[3*B +: B] = v.t3;
    vif.type_sorted[4*B +: B] = v.t4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, wait (bounded) for done, check latency and result, then settle to IDLE.
  task automatic run_vote(input vec_t v, input string tag);
    int lat;
    lat = 0;
    set_types(v);
    vif.start = 1'b1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      tick();
      vif.start = 1'b0;
      if (c == 1) chk({tag, " busy"}, int'(vif.busy), 1);
      if (vif.done) lat = c;
    end
    chk({tag, " latency"}, lat, 15);
    chk({tag, " class"}, int'(vif.class_out), v.cls);
    chk({tag, " vote_cnt"}, int'(vif.vote_cnt), v.cnt);
    chk({tag, " bad_type"}, int'(vif.bad_type), v.bad);
    tick();
  endtask

  initial begin
    int nd;
    int dcyc [4];
    int dcls [4];
    int dcnt [4];
    vec_t va, vb, vr;

`ifdef KNN_VOTE_WEIGHTED_EN
    vt[0] = mk(3, 3, 5, 3, 2,    3, 11, 0);
    vt[1] = mk(5, 2, 5, 2, 1,    5,  8, 0);
    vt[2] = mk(9, 9, 9, 1, 4,    1,  2, 1);
    vt[3] = mk(0, 1, 2, 3, 4,    0,  5, 0);
    vt[4] = mk(7, 7, 6, 6, 6,    7,  9, 0);
    vt[5] = mk(8, 9, 10, 11, 100, 0, 0, 1);
    vt[6] = mk(4, 4, 4, 4, 4,    4, 15, 0);
    vt[7] = mk(2, 6, 6, 7, 7,    6,  7, 0);
    vt[8] = mk(1, 2, 3, 1, 7,    1,  7, 0);
`else
    vt[0] = mk(3, 3, 5, 3, 2,    3,  3, 0);
    vt[1] = mk(5, 2, 5, 2, 1,    2,  2, 0);
    vt[2] = mk(9, 9, 9, 1, 4,    1,  1, 1);
    vt[3] = mk(0, 1, 2, 3, 4,    0,  1, 0);
    vt[4] = mk(7, 7, 6, 6, 6,    6,  3, 0);
    vt[5] = mk(8, 9, 10, 11, 100, 0, 0, 1);
    vt[6] = mk(4, 4, 4, 4, 4,    4,  5, 0);
    vt[7] = mk(2, 6, 6, 7, 7,    6,  2, 0);
    vt[8] = mk(1, 2, 3, 1, 7,    1,  2, 0);
`endif

    vif.start = 1'b0;
    set_types(vt[0]);
    #1;
    chk("reset busy", int'(vif.busy), 0);
    chk("reset done", int'(vif.done), 0);
    chk("reset class", int'(vif.class_out), 0);
    chk("reset vote_cnt", int'(vif.vote_cnt), 0);
    chk("reset bad_type", int'(vif.bad_type), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < NV; v++) run_vote(vt[v], $sformatf("vec%0d", v));

    // Random codes 0..9 (some illegal) against the reference tally.
    for (int r = 0; r < 30; r++) begin
      vr = mk($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
              $urandom_range(0, 9), $urandom_range(0, 9), 0, 0, 0);
      run_vote(model(vr), $sformatf("rnd%0d", r));
    end

    // Extra start pulses while busy are dropped.
    set_types(vt[0]);
    vif.start = 1'b1;
    nd = 0;
    dcyc[0] = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      vif.start = (c == 3 || c == 10);
      if (vif.done) begin
        if (nd == 0) dcyc[0] = c;
        nd++;
      end
    end
    chk("ignored start dones", nd, 1);
    chk("ignored start latency", dcyc[0], 15);

    // Start held high: back-to-back votes, and the input change after capture is not seen.
    va = vt[1];
    vb = vt[6];
    set_types(va);
    vif.start = 1'b1;
    nd = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (c == 2) set_types(vb);
      vif.start = (c < 40);
      if (vif.done && nd < 4) begin
        dcyc[nd] = c;
        dcls[nd] = int'(vif.class_out);
        dcnt[nd] = int'(vif.vote_cnt);
        nd++;
      end
    end
    chk("held start dones", nd, 3);
    chk("held first done", dcyc[0], 15);
    chk("held period", dcyc[1] - dcyc[0], 16);
    chk("held class0", dcls[0], va.cls);
    chk("held cnt0", dcnt[0], va.cnt);
    chk("held class1", dcls[1], vb.cls);
    chk("held cnt1", dcnt[1], vb.cnt);

    // Asynchronous reset mid-COUNT aborts the vote with no later done.
    set_types(vt[4]);
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    tick();
    chk("abort busy before", int'(vif.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", int'(vif.busy), 0);
    chk("abort done", int'(vif.done), 0);
    chk("abort class", int'(vif.class_out), 0);
    chk("abort vote_cnt", int'(vif.vote_cnt), 0);
    tick();
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (vif.done) nd++;
    end
    chk("abort no done", nd, 0);
    run_vote(vt[0], "post reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
